// File: rtl/magnetron_pwm_ctrl.sv
// Microwave magnetron controller: IDLE/COOK/PAUSED state machine plus a
// fixed-period PWM whose on-time is (power+1) cycles out of 2**P_W.
module magnetron_pwm_ctrl #(
  parameter int P_W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           startn,
  input  logic           stopn,
  input  logic           clearn,
  input  logic           door_closed,
  input  logic           timer_done,
  input  logic [P_W-1:0] power,
  output logic           mag_on,
  output logic           cooking,
  output logic           paused,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COOK,
    S_PAUSED
  } state_t;

  localparam logic [P_W-1:0] PHASE_MAX = '1;

  state_t         state_q, state_d;
  logic [P_W-1:0] phase_q, phase_d;
  logic [P_W-1:0] pwr_q, pwr_d;
  logic           startn_q;
  logic           armed_q;
  logic           done_q, done_d;
  logic           start_ev;
  logic           start_ok;
  logic           entering_cook;

  // armed_q masks the first edge after reset so a button held through reset
  // cannot look like a fresh press against the reset-value history.
  assign start_ev = armed_q && startn_q && !startn;
  assign start_ok = start_ev && door_closed && !timer_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clearn && start_ok) state_d = S_COOK;
      end
      S_COOK: begin
        if (!clearn)                     state_d = S_IDLE;
        else if (!door_closed || !stopn) state_d = S_PAUSED;
        else if (timer_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_PAUSED: begin
        if (!clearn) state_d = S_IDLE;
        else if (timer_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        else if (start_ok && stopn) state_d = S_COOK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entering_cook = (state_d == S_COOK) && (state_q != S_COOK);

  // Power is only sampled at period boundaries so a mid-period change never
  // produces a truncated or stretched pulse.
  always_comb begin
    phase_d = phase_q;
    pwr_d   = pwr_q;
    if (entering_cook) begin
      phase_d = '0;
      pwr_d   = power;
    end else if (state_q == S_COOK) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PHASE_MAX) pwr_d = power;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!resetn) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      pwr_q    <= '0;
      startn_q <= 1'b1;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pwr_q    <= pwr_d;
      startn_q <= startn;
      armed_q  <= 1'b1;
      done_q   <= done_d;
    end
  end

  // Door term stays combinational so opening the door cuts power with no clock delay.
  assign mag_on  = (state_q == S_COOK) && (phase_q <= pwr_q) && door_closed;
  assign cooking = (state_q == S_COOK);
  assign paused  = (state_q == S_PAUSED);
  assign done    = done_q;

endmodule

// File: tb/tb_magnetron_pwm_ctrl.sv
// Self-checking bench for magnetron_pwm_ctrl: per-scenario tasks, with PWM
// waveforms predicted into a scoreboard queue and popped cycle by cycle.
module tb_magnetron_pwm_ctrl;

  localparam int P_W    = 4;
  localparam int PERIOD = 2 ** P_W;

  logic           clk;
  logic           resetn;
  logic           startn;
  logic           stopn;
  logic           clearn;
  logic           door_closed;
  logic           timer_done;
  logic [P_W-1:0] power;
  logic           mag_on;
  logic           cooking;
  logic           paused;
  logic           done;

  int n_cmp;
  int n_err;
  logic sb[$];

  magnetron_pwm_ctrl #(.P_W(P_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .power       (power),
    .mag_on      (mag_on),
    .cooking     (cooking),
    .paused      (paused),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: outputs then show that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    startn = 1'b0;
    tick();
    startn = 1'b1;
  endtask

  task automatic go_idle();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({mag_on, cooking, paused, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000", {mag_on, cooking, paused, done});
    end
    resetn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({mag_on, cooking, paused, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected 0000", {mag_on, cooking, paused, done});
    end
  endtask

  task automatic test_pwm();
    logic exp_v;
    power = 4'd3;
    start_pulse();
    n_cmp++;
    if ({cooking, mag_on} !== 2'b11) begin
      n_err++;
      $display("FAIL start_latency: got cooking,mag_on=%b expected 11", {cooking, mag_on});
    end
    for (int i = 0; i < 2 * PERIOD; i++) sb.push_back((i % PERIOD) <= 3);
    for (int i = 0; sb.size() > 0; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (mag_on !== exp_v) begin
        n_err++;
        $display("FAIL pwm_p3 cycle %0d: got %b expected %b", i, mag_on, exp_v);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_door();
    logic exp_v;
    power = 4'd3;
    start_pulse();
    tick();
    door_closed = 1'b0;
    #1;
    n_cmp++;
    if ({cooking, mag_on} !== 2'b10) begin
      n_err++;
      $display("FAIL door_open_same_cycle: got cooking,mag_on=%b expected 10", {cooking, mag_on});
    end
    tick();
    n_cmp++;
    if ({cooking, paused} !== 2'b01) begin
      n_err++;
      $display("FAIL door_to_paused: got cooking,paused=%b expected 01", {cooking, paused});
    end
    door_closed = 1'b1;
    tick();
    n_cmp++;
    if (paused !== 1'b1) begin
      n_err++;
      $display("FAIL paused_holds: got %b expected 1", paused);
    end
    start_pulse();
    n_cmp++;
    if ({cooking, paused, mag_on} !== 3'b101) begin
      n_err++;
      $display("FAIL resume: got cooking,paused,mag_on=%b expected 101", {cooking, paused, mag_on});
    end
    for (int i = 0; i < PERIOD; i++) sb.push_back(i <= 3);
    for (int i = 0; sb.size() > 0; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (mag_on !== exp_v) begin
        n_err++;
        $display("FAIL resume_phase cycle %0d: got %b expected %b", i, mag_on, exp_v);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_stop_timer();
    start_pulse();
    tick();
    tick();
    stopn      = 1'b0;
    timer_done = 1'b1;
    tick();
    n_cmp++;
    if ({paused, done, mag_on} !== 3'b100) begin
      n_err++;
      $display("FAIL stop_beats_timer: got paused,done,mag_on=%b expected 100", {paused, done, mag_on});
    end
    tick();
    n_cmp++;
    if ({cooking, paused, done} !== 3'b001) begin
      n_err++;
      $display("FAIL paused_timer_done: got cooking,paused,done=%b expected 001", {cooking, paused, done});
    end
    timer_done = 1'b0;
    stopn      = 1'b1;
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_cycle: got %b expected 0", done);
    end
    timer_done = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({cooking, done} !== 2'b00) begin
      n_err++;
      $display("FAIL no_done_in_idle: got cooking,done=%b expected 00", {cooking, done});
    end
    timer_done = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    clearn = 1'b0;
    startn = 1'b0;
    tick();
    n_cmp++;
    if (cooking !== 1'b0) begin
      n_err++;
      $display("FAIL clear_blocks_start: got %b expected 0", cooking);
    end
    clearn = 1'b1;
    tick();
    n_cmp++;
    if (cooking !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_no_retrigger: got %b expected 0", cooking);
    end
    startn = 1'b1;
    tick();
    start_pulse();
    n_cmp++;
    if (cooking !== 1'b1) begin
      n_err++;
      $display("FAIL clear_restart: got %b expected 1", cooking);
    end
    stopn = 1'b0;
    tick();
    n_cmp++;
    if ({paused, mag_on} !== 2'b10) begin
      n_err++;
      $display("FAIL stop_latency: got paused,mag_on=%b expected 10", {paused, mag_on});
    end
    stopn      = 1'b1;
    clearn     = 1'b0;
    timer_done = 1'b1;
    tick();
    n_cmp++;
    if ({cooking, paused, done} !== 3'b000) begin
      n_err++;
      $display("FAIL clear_from_paused: got cooking,paused,done=%b expected 000", {cooking, paused, done});
    end
    clearn     = 1'b1;
    timer_done = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_no_done: got %b expected 0", done);
    end
  endtask

  task automatic test_power_change();
    logic exp_v;
    power = 4'd3;
    start_pulse();
    for (int i = 0; i < 5; i++) tick();
    power = 4'd15;
    for (int ph = 5; ph < PERIOD; ph++) sb.push_back(1'b0);
    for (int i = 0; i < 2 * PERIOD; i++) sb.push_back(1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (mag_on !== exp_v) begin
        n_err++;
        $display("FAIL power_change cycle %0d: got %b expected %b", i, mag_on, exp_v);
      end
      tick();
    end
    go_idle();
    power = 4'd3;
  endtask

  task automatic test_reset_mid_cook();
    start_pulse();
    tick();
    tick();
    n_cmp++;
    if (mag_on !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_on: got %b expected 1", mag_on);
    end
    startn = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({mag_on, cooking, paused, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got %b expected 0000", {mag_on, cooking, paused, done});
    end
    #10;
    resetn = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({mag_on, cooking} !== 2'b00) begin
      n_err++;
      $display("FAIL held_start_through_reset: got mag_on,cooking=%b expected 00", {mag_on, cooking});
    end
    startn = 1'b1;
    tick();
    start_pulse();
    n_cmp++;
    if ({cooking, mag_on} !== 2'b11) begin
      n_err++;
      $display("FAIL new_edge_after_reset: got cooking,mag_on=%b expected 11", {cooking, mag_on});
    end
    go_idle();
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    resetn      = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    timer_done  = 1'b0;
    power       = 4'd3;
    #12;
    test_reset();
    test_pwm();
    test_door();
    test_stop_timer();
    test_clear();
    test_power_change();
    test_reset_mid_cook();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/magnetron_pwm_ctrl.md
MAGNETRON_PWM_CTRL -- requirements
Module: magnetron_pwm_ctrl

Interface
REQ-001 The block SHALL have parameter P_W, default 4, the power-level and phase-counter width, giving a PWM period of 2**P_W cycles.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port startn, input, 1 bit, the active-low start button, synchronous to clk.
REQ-005 The block SHALL have port stopn, input, 1 bit, the active-low stop/pause button, level-sensitive.
REQ-006 The block SHALL have port clearn, input, 1 bit, the active-low clear button, level-sensitive.
REQ-007 The block SHALL have port door_closed, input, 1 bit, where 1 means the door is closed.
REQ-008 The block SHALL have port timer_done, input, 1 bit, where 1 means the cook timer has expired.
REQ-009 The block SHALL have port power, input, P_W bits, the requested power level; on-time is power+1 cycles per period.
REQ-010 The block SHALL have port mag_on, output, 1 bit, the magnetron enable.
REQ-011 The block SHALL have port cooking, output, 1 bit, high when state is COOK.
REQ-012 The block SHALL have port paused, output, 1 bit, high when state is PAUSED.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse on timer completion.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COOK and PAUSED.
REQ-015 A start event SHALL be a registered falling edge of startn: the previous-cycle startn is 1 and the current startn is 0. A held-low startn SHALL NOT retrigger.
REQ-016 start_ok SHALL be defined as start event AND door_closed AND NOT timer_done.
REQ-017 IDLE SHALL go to COOK on start_ok; otherwise it SHALL stay in IDLE.
REQ-018 COOK SHALL apply the following, in priority order: clearn=0 -> IDLE; door_closed=0 or stopn=0 -> PAUSED; timer_done=1 -> IDLE with done pulse; otherwise stay in COOK.
REQ-019 PAUSED SHALL apply the following, in priority order: clearn=0 -> IDLE; timer_done=1 -> IDLE with done pulse; start_ok AND stopn=1 -> COOK; otherwise stay in PAUSED.
REQ-020 clearn=0 SHALL override every other input in every state. A start event while clearn=0 SHALL be ignored.
REQ-021 done SHALL be registered and high for exactly the one cycle following the edge on which timer_done causes COOK/PAUSED -> IDLE. It SHALL NOT pulse on clear, and SHALL NOT pulse while already in IDLE.
REQ-022 The phase counter SHALL be P_W bits wide. It SHALL load 0 on every entry to COOK, increment by 1 each cycle in COOK, and wrap from 2**P_W-1 to 0. It SHALL hold its value in IDLE and PAUSED.
REQ-023 The power register pwr_q SHALL load power on every entry to COOK and at every wrap (phase = 2**P_W-1 while in COOK). A change to power mid-period SHALL take effect only at the next period boundary.
REQ-024 mag_on SHALL equal (state==COOK) AND (phase <= pwr_q) AND door_closed. The door term SHALL be combinational, so opening the door drops mag_on in the same cycle with zero latency.
REQ-025 Latency: a start event sampled at edge N SHALL give state COOK and mag_on=1 during cycle N+1. A stop sampled at edge M SHALL give mag_on=0 during cycle M+1.
REQ-026 power = 2**P_W-1 SHALL give continuous mag_on while in COOK. power = 0 SHALL give 1 cycle on and 2**P_W-1 cycles off per period.
REQ-027 cooking and paused SHALL be decoded directly from the state register; they SHALL never both be 1.

Reset
REQ-028 On resetn=0, regardless of clk: state SHALL be IDLE, phase 0, pwr_q 0, startn history 1, and done, mag_on, cooking and paused all 0.
REQ-029 Reset asserted mid-COOK SHALL drop mag_on immediately. After release, the block SHALL require a new startn falling edge to cook; a startn held low through reset SHALL NOT start.

Verification
REQ-030 P_W=4, power=3, door closed, pulse startn low for 1 cycle -> COOK; mag_on pattern is 4 cycles high, 12 low, repeating with period 16.
REQ-031 In COOK, open the door mid on-phase -> mag_on=0 in the same cycle, next state PAUSED; close the door and pulse startn -> COOK, with phase restarting at 0.
REQ-032 In COOK, stopn=0 and timer_done=1 on the same edge -> PAUSED, done=0. A following timer_done=1 in PAUSED -> IDLE, done=1 for exactly 1 cycle.
REQ-033 clearn=0 together with a startn edge in IDLE -> stays IDLE. clearn=0 in PAUSED -> IDLE, done=0.
REQ-034 In COOK at phase 5, change power 3 -> 15 -> mag_on stays 0 until phase wraps to 0, then stays continuously high.
REQ-035 Assert resetn=0 asynchronously mid-COOK with startn held low, then release -> all outputs 0 and the block stays IDLE until startn rises and falls again.
